// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants and FSM encoding for the UART command frame controller.
// Byte values and opcode defaults live here so bench and RTL agree.
package uart_cmd_ctrl_pkg;

   localparam logic [7:0] SYNC_BYTE  = 8'hA5;
   localparam logic [7:0] ACK_BYTE   = 8'h06;
   localparam logic [7:0] NAK_BYTE   = 8'h15;
   localparam logic [7:0] CMD_WR_DEF = 8'h57;
   localparam logic [7:0] CMD_RD_DEF = 8'h52;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_ADDR    = 3'd2,
      ST_DATA    = 3'd3,
      ST_CSUM    = 3'd4,
      ST_EXEC    = 3'd5,
      ST_RD_WAIT = 3'd6,
      ST_RESP    = 3'd7
   } state_t;

endpackage

// File: rtl/uart_cmd_ctrl_timer.sv
// Inter-byte timeout counter: counts baud ticks while enabled, clear wins.
// The count parks at the limit so expired stays high until cleared.
module uart_frame_timer #(
   parameter int TIMEOUT_TICKS = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT_TICKS);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && count != LIMIT) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/CMD/ADDR/DATA/CSUM frames from the UART receiver,
// runs one register access and returns a single response byte.
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter int         TIMEOUT_TICKS = 1024,
   parameter logic [7:0] CMD_WR        = CMD_WR_DEF,
   parameter logic [7:0] CMD_RD        = CMD_RD_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       baud_tick,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr_en,
   output logic       reg_rd_en,
   input  logic [7:0] reg_rdata,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       frame_err,
   output logic [7:0] err_count
);

   state_t     state_q, state_d;
   logic [7:0] cmd_q, addr_q, data_q;
   logic [7:0] tx_d;
   logic       ld_cmd, ld_addr, ld_data, ld_bus, ld_tx;
   logic       err_ev;
   logic       in_frame, tmr_clr, tmr_en, expired;
   logic       is_wr, op_ok, sum_ok;

   assign in_frame = (state_q == ST_CMD)  || (state_q == ST_ADDR) ||
                     (state_q == ST_DATA) || (state_q == ST_CSUM);
   assign tmr_clr  = rx_valid || (state_q == ST_IDLE);
   assign tmr_en   = baud_tick && in_frame;

   uart_frame_timer #(
      .TIMEOUT_TICKS(TIMEOUT_TICKS)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (tmr_clr),
      .enable (tmr_en),
      .expired(expired)
   );

   assign is_wr  = (cmd_q == CMD_WR);
   assign op_ok  = is_wr || (cmd_q == CMD_RD);
   assign sum_ok = (rx_data == (cmd_q ^ addr_q ^ data_q));

   always_comb begin
      state_d = state_q;
      ld_cmd  = 1'b0;
      ld_addr = 1'b0;
      ld_data = 1'b0;
      ld_bus  = 1'b0;
      ld_tx   = 1'b0;
      tx_d    = tx_data;
      err_ev  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_CMD;
         end
         ST_CMD: begin
            if (rx_valid) begin
               ld_cmd  = 1'b1;
               state_d = ST_ADDR;
            end else if (expired) begin
               err_ev  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (rx_valid) begin
               ld_addr = 1'b1;
               state_d = ST_DATA;
            end else if (expired) begin
               err_ev  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (rx_valid) begin
               ld_data = 1'b1;
               state_d = ST_CSUM;
            end else if (expired) begin
               err_ev  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_CSUM: begin
            if (rx_valid) begin
               if (sum_ok && op_ok) begin
                  ld_bus  = 1'b1;
                  state_d = ST_EXEC;
               end else begin
                  err_ev  = 1'b1;
                  ld_tx   = 1'b1;
                  tx_d    = NAK_BYTE;
                  state_d = ST_RESP;
               end
            end else if (expired) begin
               err_ev  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (is_wr) begin
               ld_tx   = 1'b1;
               tx_d    = ACK_BYTE;
               state_d = ST_RESP;
            end else begin
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            ld_tx   = 1'b1;
            tx_d    = reg_rdata;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (tx_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // bytes arriving while a frame executes or responds are lost
      if (rx_valid && !in_frame && state_q != ST_IDLE) err_ev = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cmd_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         tx_data   <= '0;
         frame_err <= 1'b0;
         err_count <= '0;
      end else begin
         state_q   <= state_d;
         frame_err <= err_ev;
         if (ld_cmd)  cmd_q  <= rx_data;
         if (ld_addr) addr_q <= rx_data;
         if (ld_data) data_q <= rx_data;
         if (ld_bus) begin
            reg_addr  <= addr_q;
            reg_wdata <= data_q;
         end
         if (ld_tx) tx_data <= tx_d;
         if (err_ev && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign tx_valid  = (state_q == ST_RESP);
   assign reg_wr_en = (state_q == ST_EXEC) && is_wr;
   assign reg_rd_en = (state_q == ST_EXEC) && (cmd_q == CMD_RD);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame table plus timeout,
// backpressure, reset and saturation sequences.
module tb_uart_cmd_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       baud_tick = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic [7:0] reg_addr, reg_wdata, reg_rdata = '0;
   logic       reg_wr_en, reg_rd_en;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b1;
   logic       busy, frame_err;
   logic [7:0] err_count;

   uart_cmd_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .baud_tick(baud_tick),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .reg_addr (reg_addr),
      .reg_wdata(reg_wdata),
      .reg_wr_en(reg_wr_en),
      .reg_rd_en(reg_rd_en),
      .reg_rdata(reg_rdata),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .frame_err(frame_err),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   int n_wr = 0, n_rd = 0, n_ferr = 0, n_tx = 0, n_txv = 0, n_both = 0;
   logic [7:0] last_tx = '0;

   always @(negedge clk) begin
      if (reg_wr_en) n_wr <= n_wr + 1;
      if (reg_rd_en) n_rd <= n_rd + 1;
      if (reg_wr_en && reg_rd_en) n_both <= n_both + 1;
      if (frame_err) n_ferr <= n_ferr + 1;
      if (tx_valid) n_txv <= n_txv + 1;
      if (tx_valid && tx_ready) begin
         n_tx    <= n_tx + 1;
         last_tx <= tx_data;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [39:0] f);
      for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8]);
   endtask

   typedef struct {
      logic [39:0] frame;
      logic [7:0]  rdata;
      int          wr;
      int          rd;
      logic [7:0]  addr;
      logic [7:0]  wdata;
      logic [7:0]  tx;
      int          ferr;
   } vec_t;

   vec_t vecs [6];

   int w0, r0, f0, t0, v0, at, bad;
   bit found;

   initial begin
      vecs[0] = '{40'hA5_57_10_3C_7B, 8'h00, 1, 0, 8'h10, 8'h3C, 8'h06, 0};
      vecs[1] = '{40'hA5_52_22_00_70, 8'hC3, 0, 1, 8'h22, 8'h00, 8'hC3, 0};
      vecs[2] = '{40'hA5_57_10_3C_00, 8'h00, 0, 0, 8'h22, 8'h00, 8'h15, 1};
      vecs[3] = '{40'hA5_41_01_02_42, 8'h00, 0, 0, 8'h22, 8'h00, 8'h15, 1};
      vecs[4] = '{40'hA5_57_A5_A5_57, 8'h00, 1, 0, 8'hA5, 8'hA5, 8'h06, 0};
      vecs[5] = '{40'hA5_52_FF_5A_F7, 8'h3C, 0, 1, 8'hFF, 8'h5A, 8'h3C, 0};

      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_txv", tx_valid, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_errcnt", err_count, 0);
      chk("rst_strobes", {reg_wr_en, reg_rd_en}, 0);
      chk("rst_bus", {reg_addr, reg_wdata, tx_data}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vecs[k]) begin
         reg_rdata = vecs[k].rdata;
         w0 = n_wr; r0 = n_rd; f0 = n_ferr; t0 = n_tx;
         send_frame(vecs[k].frame);
         repeat (4) @(posedge clk);
         #1;
         chk($sformatf("v%0d_wr", k), n_wr - w0, vecs[k].wr);
         chk($sformatf("v%0d_rd", k), n_rd - r0, vecs[k].rd);
         chk($sformatf("v%0d_addr", k), reg_addr, vecs[k].addr);
         chk($sformatf("v%0d_wdata", k), reg_wdata, vecs[k].wdata);
         chk($sformatf("v%0d_ntx", k), n_tx - t0, 1);
         chk($sformatf("v%0d_tx", k), last_tx, vecs[k].tx);
         chk($sformatf("v%0d_ferr", k), n_ferr - f0, vecs[k].ferr);
         chk($sformatf("v%0d_busy", k), busy, 0);
      end
      chk("tbl_errcnt", err_count, 2);

      f0 = n_ferr;
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h00);
      repeat (2) @(posedge clk);
      #1;
      chk("junk_ferr", n_ferr - f0, 0);
      chk("junk_busy", busy, 0);

      t0 = n_tx; v0 = n_txv;
      send_byte(8'hA5);
      send_byte(8'h57);
      baud_tick = 1'b1;
      found = 1'b0;
      at = 0;
      for (int i = 1; i <= 1100 && !found; i++) begin
         @(negedge clk);
         if (frame_err) begin
            found = 1'b1;
            at = i;
         end
      end
      baud_tick = 1'b0;
      chk("to_seen", found, 1);
      chk("to_cycle", at, 1026);
      chk("to_busy", busy, 0);
      chk("to_no_tx", n_txv - v0, 0);
      chk("to_errcnt", err_count, 3);

      @(posedge clk); #1;
      tx_ready = 1'b0;
      f0 = n_ferr; t0 = n_tx;
      send_frame(40'hA5_57_10_3C_7B);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge clk); #1;
         found = tx_valid;
      end
      chk("bp_txv_seen", found, 1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         rx_data  = 8'h11;
         rx_valid = (i == 5);
         if (!tx_valid || tx_data !== 8'h06) bad++;
      end
      chk("bp_stable", bad, 0);
      chk("bp_drop_ferr", n_ferr - f0, 1);
      chk("bp_errcnt", err_count, 4);
      chk("bp_held", n_tx - t0, 0);
      tx_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle", busy, 0);
      chk("bp_ntx", n_tx - t0, 1);
      chk("bp_tx", last_tx, 8'h06);

      send_byte(8'hA5);
      send_byte(8'h57);
      chk("ra_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("ra_busy0", busy, 0);
      chk("ra_errcnt0", err_count, 0);
      chk("ra_bus0", {reg_addr, reg_wdata, tx_data}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      w0 = n_wr; f0 = n_ferr;
      send_byte(8'hA5);
      send_byte(8'h57);
      send_byte(8'h10);
      send_byte(8'h3C);
      @(posedge clk); #1;
      rx_data  = 8'h7B;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      chk("lat_wr", {reg_wr_en, tx_valid}, 2'b10);
      chk("lat_bus", {reg_addr, reg_wdata}, 16'h103C);
      @(posedge clk); #1;
      chk("lat_tx", {reg_wr_en, tx_valid}, 2'b01);
      chk("lat_txdata", tx_data, 8'h06);
      @(posedge clk); #1;
      chk("ra_nwr", n_wr - w0, 1);
      chk("ra_ferr", n_ferr - f0, 0);

      tx_ready = 1'b0;
      send_frame(40'hA5_57_10_3C_7B);
      @(posedge clk); #1;
      chk("rr_txv", tx_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rr_txv0", tx_valid, 0);
      chk("rr_txd0", tx_data, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tx_ready = 1'b1;

      f0 = n_ferr;
      for (int i = 0; i < 300; i++) begin
         send_frame(40'hA5_57_10_3C_00);
         repeat (2) @(posedge clk);
      end
      #1;
      chk("sat_pulses", n_ferr - f0, 300);
      chk("sat_errcnt", err_count, 8'hFF);
      chk("never_both", n_both, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
